// File: rtl/div_radix2_core_pkg.sv
// div_radix2_core_pkg
//   Shared types and constants for the radix-2 restoring divider.
//   - div_state_e : FSM state encoding (DIV_IDLE, DIV_ITER, DIV_FIX, DIV_DONE)
//   - DIV_CNT_W   : iteration down-counter width
//   - cond_neg()  : 32-bit two's complement negate when the flag is set
//   Optional feature macro: DIV_EARLY_OUT_EN (used by div_radix2_core).
package div_radix2_core_pkg;

   localparam int DIV_CNT_W = 6;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ITER = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
      return neg ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/div_clz32.sv
// div_clz32
//   Combinational 32-bit leading-zero count.
//   Ports:
//     a : in  32  value to scan
//     z : out 6   number of leading zeros, 0..32 (32 when a == 0)
module div_clz32 (
   input  logic [31:0] a,
   output logic [5:0]  z
);

   // Scan upward from the LSB so the highest set bit is the last to win.
   always_comb begin
      z = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (a[i]) z = 6'(31 - i);
      end
   end

endmodule

// File: rtl/div_radix2_core.sv
// div_radix2_core
//   Iterative radix-2 restoring divider (DIV/DIVU/MOD/MODU), responder side of
//   the ALU enable/ready/complete handshake.
//   Ports:
//     clk      : in  1   core clock, rising edge
//     rstn     : in  1   asynchronous active-low reset
//     enable   : in  1   level request, sampled only in IDLE
//     sign_en  : in  1   1 = signed operation, sampled with enable
//     op1      : in  32  dividend, sampled with enable
//     op2      : in  32  divisor, sampled with enable
//     quo_o    : out 32  quotient, registered, held until next result
//     rem_o    : out 32  remainder, registered, held until next result
//     ready    : out 1   idle, or results valid this cycle
//     complete : out 1   one-cycle pulse, results valid this cycle
//   Macro DIV_EARLY_OUT_EN: skip iterations over the dividend's leading zeros.
//   Without it latency is a fixed 34 cycles from the accept cycle.
module div_radix2_core
   import div_radix2_core_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic              sign_en,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic [DATA_W-1:0] quo_o,
   output logic [DATA_W-1:0] rem_o,
   output logic              ready,
   output logic              complete
);

   div_state_e           state, state_nxt;
   logic [DIV_CNT_W-1:0] cnt, cnt_init;
   logic [DATA_W:0]      r;
   logic [DATA_W-1:0]    q, d;
   logic                 nq, nr;

   logic [DATA_W-1:0]    a_in, d_in, q_init;
   logic                 skip_iter;
   logic [DATA_W:0]      t;

   // Operand magnitudes; abs(0x8000_0000) wraps to itself, which the
   // unsigned datapath handles correctly.
   assign a_in = (sign_en && op1[DATA_W-1]) ? (DATA_W'(0) - op1) : op1;
   assign d_in = (sign_en && op2[DATA_W-1]) ? (DATA_W'(0) - op2) : op2;

`ifdef DIV_EARLY_OUT_EN
   logic [5:0] z;

   div_clz32 u_clz (
      .a (a_in),
      .z (z)
   );

   // Skipped leading iterations would have produced quotient bits of 0,
   // except with a zero divisor where every step succeeds and yields 1.
   // Those bits sit in the low end of q and shift up into the quotient's
   // top bits, so the result matches the full-length iteration.
   assign q_init    = (a_in << z) | ((d_in == '0) ? ~({DATA_W{1'b1}} << z) : '0);
   assign cnt_init  = DIV_CNT_W'(6'd31 - z);
   assign skip_iter = z[5];
`else
   assign q_init    = a_in;
   assign cnt_init  = DIV_CNT_W'(31);
   assign skip_iter = 1'b0;
`endif

   // Trial subtraction of the shifted partial remainder.
   assign t = {r[DATA_W-1:0], q[DATA_W-1]} - {1'b0, d};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= DIV_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      complete  = 1'b0;
      unique case (state)
         DIV_IDLE: begin
            ready = 1'b1;
            if (enable) state_nxt = skip_iter ? DIV_FIX : DIV_ITER;
         end
         DIV_ITER: if (cnt == '0) state_nxt = DIV_FIX;
         DIV_FIX:  state_nxt = DIV_DONE;
         DIV_DONE: begin
            ready     = 1'b1;
            complete  = 1'b1;
            state_nxt = DIV_IDLE;
         end
         default:  state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt   <= '0;
         r     <= '0;
         q     <= '0;
         d     <= '0;
         nq    <= 1'b0;
         nr    <= 1'b0;
         quo_o <= '0;
         rem_o <= '0;
      end else begin
         unique case (state)
            DIV_IDLE: if (enable) begin
               cnt <= cnt_init;
               r   <= '0;
               q   <= q_init;
               d   <= d_in;
               nq  <= sign_en & (op1[DATA_W-1] ^ op2[DATA_W-1]);
               nr  <= sign_en & op1[DATA_W-1];
            end
            DIV_ITER: begin
               cnt <= cnt - 1'b1;
               if (!t[DATA_W]) begin
                  r <= t;
                  q <= {q[DATA_W-2:0], 1'b1};
               end else begin
                  r <= {r[DATA_W-1:0], q[DATA_W-1]};
                  q <= {q[DATA_W-2:0], 1'b0};
               end
            end
            DIV_FIX: begin
               quo_o <= cond_neg(q, nq);
               rem_o <= cond_neg(r[DATA_W-1:0], nr);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_radix2_core.sv
// tb_div_radix2_core
//   Self-checking bench for div_radix2_core: directed corners, reset during a
//   division, held-enable back-to-back operation and random operands checked
//   against an arithmetic reference model.
module tb_div_radix2_core;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic        sign_en = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [31:0] quo_o, rem_o;
   logic        ready, complete;

   int nchecks = 0;
   int nerr    = 0;

   div_radix2_core #(.DATA_W(32)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .enable   (enable),
      .sign_en  (sign_en),
      .op1      (op1),
      .op2      (op2),
      .quo_o    (quo_o),
      .rem_o    (rem_o),
      .ready    (ready),
      .complete (complete)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: magnitude division with x/0 = all ones, x%0 = x, then sign
   // fix-up with 32-bit wrap.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, output logic [31:0] q,
                                   output logic [31:0] r);
      logic [31:0] ma, mb, mq, mr;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (mb == 0) begin
         mq = 32'hFFFF_FFFF;
         mr = ma;
      end else begin
         mq = ma / mb;
         mr = ma % mb;
      end
      q = (s && (a[31] ^ b[31])) ? -mq : mq;
      r = (s && a[31]) ? -mr : mr;
   endfunction

   function automatic int exp_lat(input logic [31:0] a, input logic s);
`ifdef DIV_EARLY_OUT_EN
      logic [31:0] m;
      int          bits;
      m = (s && a[31]) ? -a : a;
      bits = 0;
      while (m != 0) begin
         bits++;
         m = m >> 1;
      end
      return 2 + bits;
`else
      return 34 + 0 * int'(a[0] ^ s);
`endif
   endfunction

   // Drive a request in cycle 0, then scramble the operand inputs right after
   // the accept edge: the result must come from the accepted values.
   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      op1 = a; op2 = b; sign_en = s; enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      op1 = $urandom; op2 = $urandom; sign_en = 1'(~s);
   endtask

   // Count cycles to complete (bounded); rdy_hi counts cycles with ready set
   // before complete.
   task automatic wait_done(output int lat, output int rdy_hi);
      lat = -1;
      rdy_hi = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (complete) begin
            lat = c;
            break;
         end
         if (ready) rdy_hi++;
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s);
      logic [31:0] eq, er;
      int lat, rh;
      ref_div(a, b, s, eq, er);
      start(a, b, s);
      wait_done(lat, rh);
      chk({tag, "_quo"}, quo_o, eq);
      chk({tag, "_rem"}, rem_o, er);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, s)));
      chk({tag, "_rdy_lo"}, 32'(rh), 32'd0);
      @(negedge clk);
      chk({tag, "_pulse1"}, 32'(complete), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          acc_cyc [$];
      logic [31:0] acc_a [$];
      logic [31:0] acc_b [$];
      logic        acc_s [$];
      int          npulse, prev_c;
      logic [31:0] eq, er;

      // Reset state
      #3;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_complete", 32'(complete), 32'd0);
      chk("rst_quo", quo_o, 32'd0);
      chk("rst_rem", rem_o, 32'd0);
      #9 rstn = 1'b1;

      // Directed cases
      run("u100_7", 32'd100, 32'd7, 1'b0);
      chk("u100_7_q14", quo_o, 32'd14);
      run("sm100_7", 32'hFFFF_FF9C, 32'd7, 1'b1);
      chk("sm100_7_qm14", quo_o, 32'hFFFF_FFF2);
      chk("sm100_7_rm2", rem_o, 32'hFFFF_FFFE);
      run("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1);
      run("div0_u", 32'd123, 32'd0, 1'b0);
      chk("div0_u_q", quo_o, 32'hFFFF_FFFF);
      run("div0_s", 32'd123, 32'd0, 1'b1);
      chk("div0_s_r", rem_o, 32'd123);
      run("ovf_s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("ovf_s_q", quo_o, 32'h8000_0000);
      run("max_u", 32'hFFFF_FFFF, 32'd1, 1'b0);
      run("zero_u", 32'd0, 32'd9, 1'b0);
      run("zero_s", 32'd0, 32'hFFFF_FFFD, 1'b1);
      run("u5_2", 32'd5, 32'd2, 1'b0);

      // Reset in cycle 10 of a division
      start(32'd100, 32'd7, 1'b0);
      repeat (10) @(negedge clk);
      chk("mid_ready_lo", 32'(ready), 32'd0);
      #1 rstn = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(ready), 32'd1);
      chk("mid_rst_complete", 32'(complete), 32'd0);
      chk("mid_rst_quo", quo_o, 32'd0);
      chk("mid_rst_rem", rem_o, 32'd0);
      @(posedge clk);
      #2 rstn = 1'b1;
      run("post_rst_9_3", 32'd9, 32'd3, 1'b0);
      chk("post_rst_q3", quo_o, 32'd3);

      // enable held high, operands changing every cycle
      npulse = 0;
      prev_c = -100;
      for (int c = 0; c < 160; c++) begin
         @(negedge clk);
         if (complete) begin
            npulse++;
            chk("hold_no_double", 32'(c - prev_c > 1), 32'd1);
            prev_c = c;
            if (acc_cyc.size() == 0) begin
               chk("hold_spurious", 32'd1, 32'd0);
            end else begin
               ra = acc_a.pop_front();
               rb = acc_b.pop_front();
               rs = acc_s.pop_front();
               ref_div(ra, rb, rs, eq, er);
               chk("hold_quo", quo_o, eq);
               chk("hold_rem", rem_o, er);
               chk("hold_lat", 32'(c - acc_cyc.pop_front()), 32'(exp_lat(ra, rs)));
            end
         end
         op1 = $urandom;
         op2 = $urandom_range(1, 5000);
         sign_en = 1'($urandom);
         enable = 1'b1;
         if (ready && !complete) begin
            acc_cyc.push_back(c);
            acc_a.push_back(op1);
            acc_b.push_back(op2);
            acc_s.push_back(sign_en);
         end
      end
      enable = 1'b0;
      chk("hold_pulses_ge4", 32'(npulse >= 4), 32'd1);
      repeat (40) @(negedge clk);
      chk("hold_idle", 32'(ready), 32'd1);

      // Random operands
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case (i % 4)
            0: rb = $urandom;
            1: rb = $urandom_range(1, 255);
            2: begin rb = $urandom; ra = ra >> $urandom_range(0, 31); end
            default: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
         endcase
         run("rnd", ra, rb, 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
